// File: rtl/wasm_pkg.sv
// Shared opcodes, value/trap codes and FSM encodings for the wasm_core stack machine.
package wasm_pkg;

   localparam logic [7:0] OP_UNREACHABLE = 8'h00;
   localparam logic [7:0] OP_NOP         = 8'h01;
   localparam logic [7:0] OP_END         = 8'h0B;
   localparam logic [7:0] OP_DROP        = 8'h1A;
   localparam logic [7:0] OP_GET_LOCAL   = 8'h20;
   localparam logic [7:0] OP_SET_LOCAL   = 8'h21;
   localparam logic [7:0] OP_TEE_LOCAL   = 8'h22;
   localparam logic [7:0] OP_I32_CONST   = 8'h41;
   localparam logic [7:0] OP_I64_CONST   = 8'h42;
   localparam logic [7:0] OP_F32_CONST   = 8'h43;
   localparam logic [7:0] OP_F64_CONST   = 8'h44;
   localparam logic [7:0] OP_I32_ADD     = 8'h6A;
   localparam logic [7:0] OP_I32_SUB     = 8'h6B;
   localparam logic [7:0] OP_I64_ADD     = 8'h7C;
   localparam logic [7:0] OP_I64_SUB     = 8'h7D;

   localparam logic [1:0] TY_I32 = 2'd0;
   localparam logic [1:0] TY_I64 = 2'd1;
   localparam logic [1:0] TY_F32 = 2'd2;
   localparam logic [1:0] TY_F64 = 2'd3;

   localparam logic [3:0] TRAP_NONE            = 4'd0;
   localparam logic [3:0] TRAP_ENDED           = 4'd1;
   localparam logic [3:0] TRAP_UNREACHABLE     = 4'd2;
   localparam logic [3:0] TRAP_ILLEGAL_OP      = 4'd3;
   localparam logic [3:0] TRAP_STACK_OVERFLOW  = 4'd4;
   localparam logic [3:0] TRAP_STACK_UNDERFLOW = 4'd5;
   localparam logic [3:0] TRAP_NO_64B          = 4'd6;
   localparam logic [3:0] TRAP_NO_FPU          = 4'd7;
   localparam logic [3:0] TRAP_MEM_ERROR       = 4'd8;
   localparam logic [3:0] TRAP_TYPE_MISMATCH   = 4'd9;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_LOCALS = 2'd2;
   localparam logic [1:0] ST_HALT   = 2'd3;

   // Body parsing phase: local-group count, one local group, then code.
   localparam logic [1:0] PH_GROUPS = 2'd0;
   localparam logic [1:0] PH_GROUP  = 2'd1;
   localparam logic [1:0] PH_CODE   = 2'd2;

   function automatic logic is_type_byte(input logic [7:0] b);
      return (b >= 8'h7C) && (b <= 8'h7F);
   endfunction

   function automatic logic [1:0] type_code(input logic [7:0] b);
      return 2'(8'h7F - b);
   endfunction

endpackage

// File: rtl/leb128_decode.sv
// Combinational LEB128 decoder over a 16-byte window; reports value, byte length and overflow.
module leb128_decode
   import wasm_pkg::*;
(
   input  logic [127:0] i_win,
   input  logic         i_signed,
   input  logic [3:0]   i_max,
   output logic [63:0]  o_value,
   output logic [4:0]   o_len,
   output logic         o_ovf
);

   logic [63:0] w_acc;
   logic [4:0]  w_len;
   logic        w_done;
   logic        w_sgn;

   always_comb begin
      w_acc  = '0;
      w_len  = '0;
      w_done = 1'b0;
      w_sgn  = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!w_done) begin
            if (k < 10) w_acc = w_acc | (64'(i_win[8*k +: 7]) << (7 * k));
            if (!i_win[8*k+7]) begin
               w_done = 1'b1;
               w_len  = 5'(k + 1);
               w_sgn  = i_win[8*k+6];
            end
         end
      end
      o_value = w_acc;
      // A 10-byte encoding already covers all 64 bits, so only shorter ones sign-extend.
      if (i_signed && w_sgn && (w_len < 5'd10)) o_value = w_acc | ({64{1'b1}} << (7 * w_len));
      o_len = w_len;
      o_ovf = !w_done || (w_len > {1'b0, i_max});
   end

endmodule

// File: rtl/wasm_core.sv
// WebAssembly-subset stack machine: parses local declarations, then fetches and executes
// one instruction per FETCH/DECODE pair, exposing any stack slot and a sticky trap code.
module wasm_core
   import wasm_pkg::*;
#(
   parameter bit          HAS_FPU     = 1'b1,
   parameter bit          USE_64B     = 1'b1,
   parameter int unsigned MEM_DEPTH   = 6,
   parameter int unsigned STACK_DEPTH = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [MEM_DEPTH:0]   pc,
   input  logic [STACK_DEPTH:0] index,
   output logic [63:0]          result,
   output logic [1:0]           result_type,
   output logic                 result_empty,
   output logic [3:0]           trap,
   output logic [MEM_DEPTH:0]   mem_addr,
   output logic [3:0]           mem_extra,
   input  logic [127:0]         mem_data,
   input  logic                 mem_error
);

   localparam int unsigned AW    = MEM_DEPTH + 1;
   localparam int unsigned SW    = STACK_DEPTH + 1;
   localparam int unsigned NSLOT = 1 << SW;

   logic [1:0]    r_state, w_state;
   logic [1:0]    r_phase, w_phase;
   logic [AW-1:0] r_pc, w_pc;
   logic [SW:0]   r_sp, w_sp;
   logic [SW:0]   r_nloc, w_nloc;
   logic [3:0]    r_trap, w_trap;
   logic [31:0]   r_groups, w_groups;
   logic [31:0]   r_lcnt, w_lcnt;
   logic [1:0]    r_ltype, w_ltype;
   logic [63:0]   r_val [NSLOT];
   logic [1:0]    r_typ [NSLOT];

   logic          w_we;
   logic [SW-1:0] w_wa;
   logic [63:0]   w_wv;
   logic [1:0]    w_wt;

   logic [7:0]    w_op;
   logic [127:0]  w_win;
   logic          w_signed;
   logic [3:0]    w_max;
   logic [63:0]   w_leb_val;
   logic [4:0]    w_leb_len;
   logic          w_leb_ovf;
   logic [7:0]    w_tbyte;
   logic [SW-1:0] w_top_i, w_sec_i, w_lidx, w_ri;
   logic [63:0]   w_a, w_b;
   logic [1:0]    w_ta, w_tb;
   logic          w_full, w_idx_ok;
   logic [AW-1:0] w_pc_leb;

   leb128_decode u_leb (
      .i_win    (w_win),
      .i_signed (w_signed),
      .i_max    (w_max),
      .o_value  (w_leb_val),
      .o_len    (w_leb_len),
      .o_ovf    (w_leb_ovf)
   );

   always_comb begin
      w_op = mem_data[7:0];
      if (r_phase == PH_CODE) begin
         // Immediate starts after the opcode; the 0x80 filler stops a LEB from ending off-window.
         w_win    = {8'h80, mem_data[127:8]};
         w_signed = (w_op == OP_I32_CONST) || (w_op == OP_I64_CONST);
         w_max    = (w_op == OP_I64_CONST) ? 4'd10 : 4'd5;
      end else begin
         w_win    = mem_data;
         w_signed = 1'b0;
         w_max    = 4'd5;
      end
   end

   assign w_tbyte  = 8'(mem_data >> {w_leb_len, 3'b000});
   assign w_top_i  = r_sp[SW-1:0] - SW'(1);
   assign w_sec_i  = r_sp[SW-1:0] - SW'(2);
   assign w_lidx   = w_leb_val[SW-1:0];
   assign w_a      = r_val[w_sec_i];
   assign w_b      = r_val[w_top_i];
   assign w_ta     = r_typ[w_sec_i];
   assign w_tb     = r_typ[w_top_i];
   assign w_full   = (r_sp == (SW+1)'(NSLOT));
   assign w_idx_ok = !w_leb_ovf && (w_leb_val < 64'(r_nloc));
   assign w_pc_leb = r_pc + AW'(w_leb_len) + AW'(1);

   always_comb begin
      w_state  = r_state;
      w_phase  = r_phase;
      w_pc     = r_pc;
      w_sp     = r_sp;
      w_nloc   = r_nloc;
      w_trap   = r_trap;
      w_groups = r_groups;
      w_lcnt   = r_lcnt;
      w_ltype  = r_ltype;
      w_we     = 1'b0;
      w_wa     = r_sp[SW-1:0];
      w_wv     = '0;
      w_wt     = TY_I32;
      case (r_state)
         ST_FETCH: w_state = ST_DECODE;
         ST_DECODE: begin
            w_state = ST_FETCH;
            if (mem_error) begin
               w_trap = TRAP_MEM_ERROR;
            end else if (r_phase == PH_GROUPS) begin
               if (w_leb_ovf) w_trap = TRAP_ILLEGAL_OP;
               else begin
                  w_groups = w_leb_val[31:0];
                  w_pc     = r_pc + AW'(w_leb_len);
                  w_phase  = (w_leb_val == '0) ? PH_CODE : PH_GROUP;
               end
            end else if (r_phase == PH_GROUP) begin
               if (w_leb_ovf || !is_type_byte(w_tbyte)) w_trap = TRAP_ILLEGAL_OP;
               else if (!USE_64B && ((w_tbyte == 8'h7E) || (w_tbyte == 8'h7C)))
                  w_trap = TRAP_NO_64B;
               else begin
                  w_pc    = w_pc_leb;
                  w_lcnt  = w_leb_val[31:0];
                  w_ltype = type_code(w_tbyte);
                  if (w_leb_val != '0) w_state = ST_LOCALS;
                  else begin
                     w_groups = r_groups - 32'd1;
                     w_phase  = (r_groups == 32'd1) ? PH_CODE : PH_GROUP;
                  end
               end
            end else begin
               case (w_op)
                  OP_UNREACHABLE: w_trap = TRAP_UNREACHABLE;
                  OP_NOP:         w_pc = r_pc + AW'(1);
                  OP_END:         w_trap = TRAP_ENDED;
                  OP_DROP: begin
                     if (r_sp == '0) w_trap = TRAP_STACK_UNDERFLOW;
                     else begin
                        w_sp = r_sp - (SW+1)'(1);
                        w_pc = r_pc + AW'(1);
                     end
                  end
                  OP_GET_LOCAL: begin
                     if (!w_idx_ok) w_trap = TRAP_ILLEGAL_OP;
                     else if (w_full) w_trap = TRAP_STACK_OVERFLOW;
                     else begin
                        w_we = 1'b1;
                        w_wv = r_val[w_lidx];
                        w_wt = r_typ[w_lidx];
                        w_sp = r_sp + (SW+1)'(1);
                        w_pc = w_pc_leb;
                     end
                  end
                  OP_SET_LOCAL, OP_TEE_LOCAL: begin
                     if (!w_idx_ok) w_trap = TRAP_ILLEGAL_OP;
                     else if (r_sp == '0) w_trap = TRAP_STACK_UNDERFLOW;
                     else if (w_tb != r_typ[w_lidx]) w_trap = TRAP_TYPE_MISMATCH;
                     else begin
                        w_we = 1'b1;
                        w_wa = w_lidx;
                        w_wv = w_b;
                        w_wt = w_tb;
                        if (w_op == OP_SET_LOCAL) w_sp = r_sp - (SW+1)'(1);
                        w_pc = w_pc_leb;
                     end
                  end
                  OP_I32_CONST, OP_I64_CONST: begin
                     if (!USE_64B && (w_op == OP_I64_CONST)) w_trap = TRAP_NO_64B;
                     else if (w_leb_ovf) w_trap = TRAP_ILLEGAL_OP;
                     else if (w_full) w_trap = TRAP_STACK_OVERFLOW;
                     else begin
                        w_we = 1'b1;
                        w_wv = (w_op == OP_I32_CONST) ? {32'h0, w_leb_val[31:0]} : w_leb_val;
                        w_wt = (w_op == OP_I32_CONST) ? TY_I32 : TY_I64;
                        w_sp = r_sp + (SW+1)'(1);
                        w_pc = w_pc_leb;
                     end
                  end
                  OP_F32_CONST, OP_F64_CONST: begin
                     if (!USE_64B && (w_op == OP_F64_CONST)) w_trap = TRAP_NO_64B;
                     else if (!HAS_FPU) w_trap = TRAP_NO_FPU;
                     else if (w_full) w_trap = TRAP_STACK_OVERFLOW;
                     else begin
                        w_we = 1'b1;
                        w_wv = (w_op == OP_F32_CONST) ? {32'h0, mem_data[39:8]} : mem_data[71:8];
                        w_wt = (w_op == OP_F32_CONST) ? TY_F32 : TY_F64;
                        w_sp = r_sp + (SW+1)'(1);
                        w_pc = r_pc + ((w_op == OP_F32_CONST) ? AW'(5) : AW'(9));
                     end
                  end
                  OP_I32_ADD, OP_I32_SUB, OP_I64_ADD, OP_I64_SUB: begin
                     if (!USE_64B && ((w_op == OP_I64_ADD) || (w_op == OP_I64_SUB)))
                        w_trap = TRAP_NO_64B;
                     else if (r_sp < (SW+1)'(2)) w_trap = TRAP_STACK_UNDERFLOW;
                     else if ((w_op == OP_I32_ADD) || (w_op == OP_I32_SUB)) begin
                        if ((w_ta != TY_I32) || (w_tb != TY_I32)) w_trap = TRAP_TYPE_MISMATCH;
                        else begin
                           w_we = 1'b1;
                           w_wa = w_sec_i;
                           w_wv = (w_op == OP_I32_ADD) ? {32'h0, w_a[31:0] + w_b[31:0]}
                                                       : {32'h0, w_a[31:0] - w_b[31:0]};
                           w_sp = r_sp - (SW+1)'(1);
                           w_pc = r_pc + AW'(1);
                        end
                     end else begin
                        if ((w_ta != TY_I64) || (w_tb != TY_I64)) w_trap = TRAP_TYPE_MISMATCH;
                        else begin
                           w_we = 1'b1;
                           w_wa = w_sec_i;
                           w_wv = (w_op == OP_I64_ADD) ? (w_a + w_b) : (w_a - w_b);
                           w_wt = TY_I64;
                           w_sp = r_sp - (SW+1)'(1);
                           w_pc = r_pc + AW'(1);
                        end
                     end
                  end
                  default: w_trap = TRAP_ILLEGAL_OP;
               endcase
            end
         end
         ST_LOCALS: begin
            if (w_full) w_trap = TRAP_STACK_OVERFLOW;
            else begin
               w_we   = 1'b1;
               w_wt   = r_ltype;
               w_sp   = r_sp + (SW+1)'(1);
               w_nloc = r_nloc + (SW+1)'(1);
               w_lcnt = r_lcnt - 32'd1;
               if (r_lcnt == 32'd1) begin
                  w_state  = ST_FETCH;
                  w_groups = r_groups - 32'd1;
                  w_phase  = (r_groups == 32'd1) ? PH_CODE : PH_GROUP;
               end
            end
         end
         default: ;
      endcase
      if (w_trap != TRAP_NONE) w_state = ST_HALT;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_FETCH;
         r_phase  <= PH_GROUPS;
         r_pc     <= pc;
         r_sp     <= '0;
         r_nloc   <= '0;
         r_trap   <= TRAP_NONE;
         r_groups <= '0;
         r_lcnt   <= '0;
         r_ltype  <= TY_I32;
      end else begin
         r_state  <= w_state;
         r_phase  <= w_phase;
         r_pc     <= w_pc;
         r_sp     <= w_sp;
         r_nloc   <= w_nloc;
         r_trap   <= w_trap;
         r_groups <= w_groups;
         r_lcnt   <= w_lcnt;
         r_ltype  <= w_ltype;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && w_we) begin
         r_val[w_wa] <= w_wv;
         r_typ[w_wa] <= w_wt;
      end
   end

   assign w_ri         = r_sp[SW-1:0] - index - SW'(1);
   assign result_empty = !reset || ({1'b0, index} >= r_sp);
   assign result       = result_empty ? 64'h0 : r_val[w_ri];
   assign result_type  = result_empty ? TY_I32 : r_typ[w_ri];
   assign trap         = reset ? r_trap : TRAP_NONE;
   assign mem_addr     = reset ? r_pc : pc;
   assign mem_extra    = 4'd15;

endmodule

// File: tb/tb_wasm_core.sv
// Directed bench: two cores (64-bit enabled / disabled) share one behavioural ROM image.
module tb_wasm_core;
   import wasm_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [6:0]   pc = '0;
   logic [7:0]   index = '0;
   logic [63:0]  res1, res2;
   logic [1:0]   ty1, ty2;
   logic         em1, em2;
   logic [3:0]   t1, t2;
   logic [6:0]   ma1, ma2;
   logic [3:0]   mx1, mx2;
   logic [127:0] d1 = '0, d2 = '0;
   logic         er1 = 1'b0, er2 = 1'b0;
   logic [7:0]   rom [128];
   int           ub = 255;
   int           lb = 0;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   wasm_core #(.HAS_FPU(1'b1), .USE_64B(1'b1), .MEM_DEPTH(6), .STACK_DEPTH(7)) u_dut1 (
      .clk(clk), .reset(reset), .pc(pc), .index(index), .result(res1), .result_type(ty1),
      .result_empty(em1), .trap(t1), .mem_addr(ma1), .mem_extra(mx1), .mem_data(d1),
      .mem_error(er1)
   );

   wasm_core #(.HAS_FPU(1'b1), .USE_64B(1'b0), .MEM_DEPTH(6), .STACK_DEPTH(7)) u_dut2 (
      .clk(clk), .reset(reset), .pc(pc), .index(index), .result(res2), .result_type(ty2),
      .result_empty(em2), .trap(t2), .mem_addr(ma2), .mem_extra(mx2), .mem_data(d2),
      .mem_error(er2)
   );

   function automatic logic [127:0] win(input logic [6:0] a);
      logic [127:0] w;
      w = '0;
      for (int k = 0; k < 16; k++)
         if (int'(a) + k < 128) w[8*k +: 8] = rom[int'(a) + k];
      return w;
   endfunction

   always @(posedge clk) begin
      d1  <= win(ma1);
      d2  <= win(ma2);
      er1 <= (int'(ma1) + int'(mx1) > ub) || (int'(ma1) < lb);
      er2 <= (int'(ma2) + int'(mx2) > ub) || (int'(ma2) < lb);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bytes given most-significant first: the leftmost byte lands at base.
   task automatic load(input int base, input int n, input logic [127:0] v);
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      for (int k = 0; k < n; k++) rom[base + k] = v[8*(n-1-k) +: 8];
   endtask

   task automatic hold_reset(input logic [6:0] p);
      @(negedge clk);
      reset = 1'b0;
      pc    = p;
      index = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset(input logic [6:0] p);
      hold_reset(p);
      reset = 1'b1;
   endtask

   task automatic wait_traps(input int budget);
      int c = 0;
      while ((t1 == 4'd0 || t2 == 4'd0) && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("trap_within_budget", {62'h0, t1 != 4'd0, t2 != 4'd0}, 64'd3);
   endtask

   initial begin
      int c2;
      // locals 1 x i64; i64.const 4; set_local 0; get_local 0; end
      load(54, 10, 80'h01_01_7E_42_04_21_00_20_00_0B);
      hold_reset(7'd54);
      chk("rst_trap", 64'(t1), 64'd0);
      chk("rst_empty", 64'(em1), 64'd1);
      chk("rst_result", res1, 64'd0);
      chk("rst_type", 64'(ty1), 64'd0);
      chk("rst_mem_addr", 64'(ma1), 64'd54);
      reset = 1'b1;
      c2 = 0;
      while (t2 == 4'd0 && c2 < 6) begin
         @(posedge clk);
         #1;
         c2++;
      end
      chk("no64b_trap", 64'(t2), 64'(TRAP_NO_64B));
      chk("no64b_empty", 64'(em2), 64'd1);
      wait_traps(100);
      chk("loc_trap", 64'(t1), 64'(TRAP_ENDED));
      chk("loc_top", res1, 64'd4);
      chk("loc_type", 64'(ty1), 64'(TY_I64));
      chk("loc_nonempty", 64'(em1), 64'd0);
      index = 8'd1;
      #1;
      chk("loc_slot1", res1, 64'd4);
      index = 8'd2;
      #1;
      chk("loc_slot2_empty", 64'(em1), 64'd1);

      // i32.const 0x7FFFFFFF; i32.const 1; i32.add; end
      load(0, 11, 88'h00_41_FF_FF_FF_FF_07_41_01_6A_0B);
      do_reset(7'd0);
      wait_traps(100);
      chk("add_trap", 64'(t1), 64'(TRAP_ENDED));
      chk("add_result", res1, 64'h8000_0000);
      chk("add_type", 64'(ty1), 64'(TY_I32));
      chk("add_result_no64", res2, 64'h8000_0000);

      // 0 - 1 wraps in 32 bits and stays zero-extended
      load(0, 7, 56'h00_41_00_41_01_6B_0B);
      do_reset(7'd0);
      wait_traps(100);
      chk("sub32_result", res1, 64'h0000_0000_FFFF_FFFF);

      // i64: -1 - 1
      load(0, 7, 56'h00_42_7F_42_01_7D_0B);
      do_reset(7'd0);
      wait_traps(100);
      chk("sub64_result", res1, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub64_type", 64'(ty1), 64'(TY_I64));
      chk("sub64_no64", 64'(t2), 64'(TRAP_NO_64B));

      load(0, 2, 16'h00_1A);
      do_reset(7'd0);
      wait_traps(100);
      chk("drop_underflow", 64'(t1), 64'(TRAP_STACK_UNDERFLOW));
      chk("drop_empty", 64'(em1), 64'd1);

      load(0, 6, 48'h00_41_01_42_02_7C);
      do_reset(7'd0);
      wait_traps(100);
      chk("mix_trap", 64'(t1), 64'(TRAP_TYPE_MISMATCH));
      chk("mix_top_held", res1, 64'd2);

      load(0, 7, 56'h00_43_00_00_80_3F_0B);
      do_reset(7'd0);
      wait_traps(100);
      chk("f32_result", res1, 64'h3F80_0000);
      chk("f32_type", 64'(ty1), 64'(TY_F32));

      load(0, 2, 16'h00_FF);
      do_reset(7'd0);
      wait_traps(100);
      chk("illegal_op", 64'(t1), 64'(TRAP_ILLEGAL_OP));

      load(0, 3, 24'h00_20_00);
      do_reset(7'd0);
      wait_traps(100);
      chk("local_oob", 64'(t1), 64'(TRAP_ILLEGAL_OP));

      load(0, 2, 16'h00_00);
      do_reset(7'd0);
      wait_traps(100);
      chk("unreachable", 64'(t1), 64'(TRAP_UNREACHABLE));

      // 511 i32 locals overflow the 256-entry stack
      load(0, 4, 32'h01_FF_03_7F);
      do_reset(7'd0);
      wait_traps(400);
      chk("overflow_trap", 64'(t1), 64'(TRAP_STACK_OVERFLOW));
      index = 8'd255;
      #1;
      chk("overflow_last_slot", 64'(em1), 64'd0);

      load(0, 11, 88'h00_41_FF_FF_FF_FF_07_41_01_6A_0B);
      ub = 100;
      do_reset(7'd120);
      wait_traps(100);
      chk("mem_error", 64'(t1), 64'(TRAP_MEM_ERROR));
      hold_reset(7'd0);
      chk("rst2_trap", 64'(t1), 64'd0);
      chk("rst2_mem_addr", 64'(ma1), 64'd0);
      ub = 255;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_traps(100);
      chk("restart_trap", 64'(t1), 64'(TRAP_ENDED));
      chk("restart_result", res1, 64'h8000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
